// File: rtl/wb_stage_buf.sv
// Writeback stage with a DEPTH-entry in-order retire buffer and forwarding lookups.
// Optional WS_TRACE_EN adds the debug_wb_* trace ports driven from the head entry.
module wb_stage_buf #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int PCW    = 32,
    parameter int DEPTH  = 2,
    parameter int NRD    = 2,
    parameter int BUS_WD = 2 + AW + DW + PCW
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           ms_to_ws_valid,
    input  logic [BUS_WD-1:0]              ms_to_ws_bus,
    output logic                           ws_allowin,
    output logic                           rf_we,
    output logic [AW-1:0]                  rf_waddr,
    output logic [DW-1:0]                  rf_wdata,
    input  logic                           rf_ready,
    output logic                           mem_we,
    input  logic [NRD*AW-1:0]              ds_rs_addr,
    output logic [NRD-1:0]                 ds_rs_hit,
    output logic [NRD*DW-1:0]              ds_rs_data,
`ifdef WS_TRACE_EN
    output logic [PCW-1:0]                 debug_wb_pc,
    output logic [3:0]                     debug_wb_rf_wen,
    output logic [AW-1:0]                  debug_wb_rf_wnum,
    output logic [DW-1:0]                  debug_wb_rf_wdata,
`endif
    output logic [$clog2(DEPTH+1)-1:0]     ws_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_mem_we;
    logic [DEPTH-1:0] e_gr_we;
    logic [AW-1:0]    e_dest   [DEPTH];
    logic [DW-1:0]    e_result [DEPTH];
    logic [PCW-1:0]   e_pc     [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic           in_mem_we;
    logic           in_gr_we;
    logic [AW-1:0]  in_dest;
    logic [DW-1:0]  in_result;
    logic [PCW-1:0] in_pc;

    logic head_v;
    logic push;
    logic retire;

    assign in_pc     = ms_to_ws_bus[PCW-1:0];
    assign in_result = ms_to_ws_bus[PCW +: DW];
    assign in_dest   = ms_to_ws_bus[PCW+DW +: AW];
    assign in_gr_we  = ms_to_ws_bus[PCW+DW+AW];
    assign in_mem_we = ms_to_ws_bus[BUS_WD-1];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ws_allowin = (count < CW'(DEPTH));
    assign push       = ms_to_ws_valid && ws_allowin;
    assign head_v     = e_valid[head];
    assign retire     = head_v && (!e_gr_we[head] || rf_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            if (push) begin
                e_valid[tail] <= 1'b1;
                tail          <= ptr_next(tail);
            end
            if (retire) begin
                e_valid[head] <= 1'b0;
                head          <= ptr_next(head);
            end
            unique case ({push, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload carries no reset; every consumer is gated by the valid bits.
    always_ff @(posedge clk) begin
        if (push) begin
            e_mem_we[tail] <= in_mem_we;
            e_gr_we[tail]  <= in_gr_we && (in_dest != '0);
            e_dest[tail]   <= in_dest;
            e_result[tail] <= in_result;
            e_pc[tail]     <= in_pc;
        end
    end

    assign ws_count = count;
    assign rf_we    = head_v && e_gr_we[head];
    assign rf_waddr = head_v ? e_dest[head] : '0;
    assign rf_wdata = head_v ? e_result[head] : '0;
    assign mem_we   = head_v && e_mem_we[head];

`ifdef WS_TRACE_EN
    assign debug_wb_pc       = head_v ? e_pc[head] : '0;
    assign debug_wb_rf_wen   = {4{rf_we && rf_ready}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

    // Walk oldest to youngest so the last match (nearest the tail) wins.
    always_comb begin
        logic [AW-1:0] addr;
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        int            idx_i;
        ds_rs_hit  = '0;
        ds_rs_data = '0;
        addr       = '0;
        hit        = 1'b0;
        data       = '0;
        idx        = '0;
        idx_i      = 0;
        for (int p = 0; p < NRD; p++) begin
            addr = ds_rs_addr[p*AW +: AW];
            hit  = 1'b0;
            data = '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx_i = int'(head) + k;
                if (idx_i >= DEPTH) begin
                    idx_i = idx_i - DEPTH;
                end
                idx = PW'(idx_i);
                if (e_valid[idx] && e_gr_we[idx] &&
                    (e_dest[idx] == addr) && (addr != '0)) begin
                    hit  = 1'b1;
                    data = e_result[idx];
                end
            end
            ds_rs_hit[p]           = hit;
            ds_rs_data[p*DW +: DW] = data;
        end
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Randomised and directed bench for wb_stage_buf against a queue-based model.
// Model: FIFO of entries; lookups scan youngest-first; dest 0 never writes.
module tb_wb_stage_buf;

    localparam int DW = 32, AW = 5, PCW = 32, DEPTH = 2, NRD = 2;
    localparam int BUS_WD = 2 + AW + DW + PCW;
    localparam int CW = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                resetn;
    logic                ms_to_ws_valid;
    logic [BUS_WD-1:0]   ms_to_ws_bus;
    logic                ws_allowin;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                rf_ready;
    logic                mem_we;
    logic [NRD*AW-1:0]   ds_rs_addr;
    logic [NRD-1:0]      ds_rs_hit;
    logic [NRD*DW-1:0]   ds_rs_data;
    logic [CW-1:0]       ws_count;
`ifdef WS_TRACE_EN
    logic [PCW-1:0]      debug_wb_pc;
    logic [3:0]          debug_wb_rf_wen;
    logic [AW-1:0]       debug_wb_rf_wnum;
    logic [DW-1:0]       debug_wb_rf_wdata;
`endif

    wb_stage_buf #(
        .DW(DW), .AW(AW), .PCW(PCW), .DEPTH(DEPTH), .NRD(NRD)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .rf_ready(rf_ready),
        .mem_we(mem_we),
        .ds_rs_addr(ds_rs_addr),
        .ds_rs_hit(ds_rs_hit),
        .ds_rs_data(ds_rs_data),
`ifdef WS_TRACE_EN
        .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
        .ws_count(ws_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic        gw;
        logic [4:0]  d;
        logic [31:0] r;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_model();
        logic        e_hit;
        logic [31:0] e_data;
        logic [4:0]  a;
        chk("allowin", 64'(ws_allowin), 64'(q.size() < DEPTH));
        chk("count", 64'(ws_count), 64'(q.size()));
        chk("rf_we", 64'(rf_we), 64'(q.size() > 0 && q[0].gw));
        chk("rf_waddr", 64'(rf_waddr), 64'(q.size() > 0 ? q[0].d : 5'd0));
        chk("rf_wdata", 64'(rf_wdata), 64'(q.size() > 0 ? q[0].r : 32'd0));
        chk("mem_we", 64'(mem_we), 64'(q.size() > 0 && q[0].mw));
        for (int p = 0; p < NRD; p++) begin
            a      = ds_rs_addr[p*AW +: AW];
            e_hit  = 1'b0;
            e_data = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!e_hit && q[i].gw && q[i].d == a && a != 0) begin
                    e_hit  = 1'b1;
                    e_data = q[i].r;
                end
            end
            chk("hit", 64'(ds_rs_hit[p]), 64'(e_hit));
            chk("data", 64'(ds_rs_data[p*DW +: DW]), 64'(e_data));
        end
`ifdef WS_TRACE_EN
        chk("dbg_wen", 64'(debug_wb_rf_wen),
            64'((q.size() > 0 && q[0].gw && rf_ready) ? 4'hf : 4'h0));
`endif
    endtask

    // Called just after a negedge: drive, compare, clock, update model.
    task automatic cycle(input logic rst_n, input logic v, input logic mw,
                         input logic gw, input logic [4:0] d,
                         input logic [31:0] r, input logic rdy,
                         input logic [4:0] a0, input logic [4:0] a1);
        ent_t e;
        bit   acc, ret;
        resetn         = rst_n;
        ms_to_ws_valid = v;
        ms_to_ws_bus   = {mw, gw, d, r, r ^ 32'h8000_0000};
        rf_ready       = rdy;
        ds_rs_addr     = {a1, a0};
        if (!rst_n) q.delete();
        #1;
        check_model();
        @(posedge clk);
        if (rst_n) begin
            acc = v && (q.size() < DEPTH);
            ret = (q.size() > 0) && (!q[0].gw || rdy);
            if (ret) void'(q.pop_front());
            if (acc) begin
                e.mw = mw;
                e.gw = gw && (d != 0);
                e.d  = d;
                e.r  = r;
                e.pc = r ^ 32'h8000_0000;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, rdy, 5'd0, 5'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        rf_ready       = 1'b0;
        ds_rs_addr     = '0;
        @(negedge clk);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'($urandom_range(1, 31)),
                  $urandom, 1'($urandom), 5'($urandom), 5'($urandom));
            chk("rst_allowin", 64'(ws_allowin), 64'd1);
            chk("rst_rf_we", 64'(rf_we), 64'd0);
            chk("rst_count", 64'(ws_count), 64'd0);
            chk("rst_hit", 64'(ds_rs_hit), 64'd0);
        end
        idle(1'b1);
        chk("rel_count", 64'(ws_count), 64'd0);

        // Streaming dest 3..7
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'(3 + i), 32'h100 + i, 1'b1, 5'd0, 5'd0);
            chk("str_rf_we", 64'(rf_we), 64'd1);
            chk("str_waddr", 64'(rf_waddr), 64'(3 + i));
            chk("str_wdata", 64'(rf_wdata), 64'(32'h100 + i));
            chk("str_allowin", 64'(ws_allowin), 64'd1);
        end
        idle(1'b1);
        chk("str_drain", 64'(ws_count), 64'd0);

        // Backpressure
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB, 1'b0, 5'd0, 5'd0);
        chk("bp_count", 64'(ws_count), 64'd2);
        chk("bp_allowin", 64'(ws_allowin), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hC, 1'b0, 5'd0, 5'd0);
        chk("bp_held", 64'(ws_count), 64'd2);
        chk("bp_head", 64'(rf_wdata), 64'hA);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hC, 1'b1, 5'd0, 5'd0);
        chk("bp_second", 64'(rf_wdata), 64'hB);
        chk("bp_freed", 64'(ws_allowin), 64'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hC, 1'b1, 5'd0, 5'd0);
        chk("bp_third", 64'(rf_wdata), 64'hC);
        idle(1'b1);

        // Forwarding youngest wins
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h22, 1'b0, 5'd5, 5'd0);
        #1;
        chk("fwd_hit", 64'(ds_rs_hit), 64'b01);
        chk("fwd_data0", 64'(ds_rs_data[31:0]), 64'h22);
        chk("fwd_data1", 64'(ds_rs_data[63:32]), 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd5);
        #1;
        chk("fwd_miss", 64'(ds_rs_hit), 64'b10);
        idle(1'b1);
        idle(1'b1);

        // Non-writing and dest 0 retire without rf_ready
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h55, 1'b0, 5'd9, 5'd0);
        chk("nw_mem_we", 64'(mem_we), 64'd1);
        chk("nw_rf_we", 64'(rf_we), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 5'd0);
        chk("d0_count", 64'(ws_count), 64'd1);
        chk("d0_mem_we", 64'(mem_we), 64'd0);
        chk("d0_rf_we", 64'(rf_we), 64'd0);
        idle(1'b0);
        chk("d0_drain", 64'(ws_count), 64'd0);

        // Async reset mid-flight
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 5'd0);
        chk("ar_full", 64'(ws_count), 64'd2);
        #2 resetn = 1'b0;
        q.delete();
        #1;
        chk("ar_count", 64'(ws_count), 64'd0);
        chk("ar_rf_we", 64'(rf_we), 64'd0);
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8);
        idle(1'b1);
        chk("ar_no_stale", 64'(rf_we), 64'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage_buf.md
Name: wb_stage_buf

Overview:
Parametrised successor to the single-register writeback stage. Accepts instructions from the memory stage into a DEPTH-entry in-order retire buffer, so a busy register-file write port (rf_ready low) no longer stalls the memory stage immediately. Provides NRD associative forwarding lookups into all pending writes for the decode stage, and exposes head-entry memory-write enable. Sits between mem_stage and the regfile/decode-bypass network.

Parameters:
DW, 32, result/data width
AW, 5, register address width
PCW, 32, PC width
DEPTH, 2, retire buffer entries (>=1, need not be power of 2)
NRD, 2, number of decode-stage forwarding lookup ports
BUS_WD, 2+AW+DW+PCW, ms_to_ws_bus width (derived; do not override)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ms_to_ws_valid  in  1  memory stage has an instruction
ms_to_ws_bus  in  BUS_WD  {mem_we, gr_we, dest[AW], result[DW], pc[PCW]}, MSB first
ws_allowin  out  1  buffer can accept this cycle
rf_we  out  1  head entry requests a regfile write
rf_waddr  out  AW  head dest
rf_wdata  out  DW  head result
rf_ready  in  1  regfile write port free; a write commits when rf_we && rf_ready
mem_we  out  1  head valid && head mem_we
ds_rs_addr  in  NRD*AW  packed lookup addresses, port i at [i*AW +: AW]
ds_rs_hit  out  NRD  port i hits a pending write
ds_rs_data  out  NRD*DW  forwarded data per port, 0 when no hit
ws_count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (resetn low, async): count=0, head/tail pointers=0, all entry valid bits cleared; all outputs 0 except ws_allowin=1. Entry payloads need not be reset.
- ws_allowin = (count < DEPTH); no combinational dependence on rf_ready.
- Enqueue: ms_to_ws_valid && ws_allowin -> write bus to tail, tail advances. An entry with dest==0 is stored with gr_we forced to 0.
- Head retire condition: head valid && (!gr_we || rf_ready). Entries with gr_we=0 retire one per cycle regardless of rf_ready.
- rf_we = head valid && head gr_we; rf_waddr/rf_wdata are head fields. The outputs are held stable while rf_ready is low.
- Latency: an entry enqueued into an empty buffer appears at the head/rf outputs the cycle after acceptance. Throughput is 1/cycle when rf_ready stays high.
- Simultaneous enqueue and retire: count unchanged; both pointers advance. Full with retire: ws_allowin stays low that cycle, and the freed slot is visible next cycle.
- Pointer wrap: pointer == DEPTH-1 advances to 0. Explicit compare; no reliance on power-of-2 depth.
- Lookup, port i: scan valid entries with gr_we && dest==addr_i && addr_i!=0. The youngest match, nearest the tail, wins, and the head is included. hit_i=1 with that result. No match or addr 0 gives hit_i=0 and data 0. Purely combinational on registered state; the incoming ms bus is not searched.
- Reset asserted mid-operation drops all pending entries with no regfile write.
- ws_count is updated registered, same edge as the pointers.

Optional Feature:
WS_TRACE_EN
- Defined: adds outputs debug_wb_pc[PCW], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[AW], debug_wb_rf_wdata[DW]. These carry head fields. debug_wb_rf_wen={4{rf_we&&rf_ready}} and pulses exactly once per committed write. For a gr_we=0 entry, wen=0 on its retire cycle.
- Undefined: ports and logic absent; all other behaviour is identical.

Test Plan:
- Reset: hold resetn=0 with random inputs -> ws_allowin=1, rf_we=0, ws_count=0, all hit=0. Release -> same until first valid.
- Streaming: rf_ready=1, push dest 3..7 with results 0x100..0x104 back-to-back -> rf_we each cycle one cycle later, waddr/wdata in order, ws_allowin never drops.
- Backpressure (DEPTH=2): rf_ready=0, push dest 1 (0xA) and dest 2 (0xB) -> ws_count=2, ws_allowin=0, third push held. Set rf_ready=1 -> commits 0xA then 0xB; third entry is accepted the cycle after the first commit.
- Forwarding: rf_ready=0, buffer holds dest 5=0x11 (older) and dest 5=0x22 (younger). Query addr 5 -> hit=1, data 0x22. Query addr 0 -> hit=0, data 0. Query addr 6 -> hit=0.
- Non-writing/dest0: rf_ready=0, push gr_we=0 then gr_we=1 dest 0 -> both retire on consecutive cycles, rf_we stays 0, mem_we follows the head mem_we bit.
- Async reset mid-flight: full buffer, drop resetn between edges -> count=0 and rf_we=0 immediately. After release, no stale commit occurs.
